fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer of the async FIFO, clocked in the read domain.
//  - Pops words using the FIFO's registered empty flag and increment strobe.
//  - Buffers them in a 2-entry output queue.
//  - Presents them on a valid/ready stream to the I2C master/slave TX byte path.
//  - Decouples the consumer's backpressure from the FIFO pop timing.
//  - Sustains 1 word/clk when m_ready_i is held high.
// PARAMETERS
//  DATA_SIZE  8  width of FIFO word / stream data
//  RD_LAT     0  FIFO memory read latency: 0 = rdata combinational from raddr, 1 = registered
// PORTS
//  clk_i          in   1          read-domain clock
//  rst_i          in   1          synchronous reset, active-high
//  fifo_rempty_i  in   1          FIFO empty flag (registered, already reflects the previous cycle's pop)
//  fifo_rdata_i   in   DATA_SIZE  FIFO read data at current raddr
//  fifo_rinc_o    out  1          pop strobe to FIFO read-pointer logic
//  m_valid_o      out  1          stream word valid
//  m_data_o       out  DATA_SIZE  stream word
//  m_ready_i      in   1          consumer accepts word
//  level_o        out  2          words held in output queue (0..2)
//  idle_o         out  1          queue empty and no read in flight
// BEHAVIOUR
//  Reset, synchronous (rst_i high at a posedge):
//   - Clears: cnt=0, rd_ptr=wr_ptr=0, inflight=0.
//   - Outputs after that edge: m_valid_o=0, level_o=0, idle_o=1, m_data_o=0.
//   - fifo_rinc_o is forced 0 combinationally while rst_i=1.
//  Reset mid-operation:
//   - Buffered and in-flight words are discarded.
//   - The FIFO read pointer must be reset in the same cycle by the integration.
//  Queue and outputs:
//   - 2-entry circular buffer, 1-bit rd_ptr/wr_ptr, cnt in 0..2.
//   - m_valid_o = (cnt!=0); m_data_o = buf[rd_ptr] (register output, no comb path from fifo_rdata_i).
//  Pop rule:
//   - take = m_valid_o & m_ready_i.
//   - fifo_rinc_o = ~rst_i & ~fifo_rempty_i & ((cnt + inflight - take) < 2).
//   - Never pops when empty; never overfills the queue.
//  Data capture:
//   - RD_LAT=0: on a pop, fifo_rdata_i is written to buf[wr_ptr] at the same edge.
//   - RD_LAT=1: inflight<=fifo_rinc_o; when inflight=1, fifo_rdata_i is written at the next edge.
//  Latency, FIFO non-empty to m_valid_o: RD_LAT=0 -> 1 clk after pop; RD_LAT=1 -> 2 clk.
//  Simultaneous write and take in one cycle: cnt unchanged, both pointers advance.
//  Handshake:
//   - Once m_valid_o=1, m_data_o is held stable until take.
//   - m_valid_o never drops without take (except reset/flush).
//  Counters: cnt never exceeds 2 and never underflows; assertion-checked in the bench.
//  level_o = cnt; idle_o = (cnt==0) & ~inflight.
// CONFIGURATION
//  Macro: FIFO_RD_STREAM_FLUSH_EN.
//  Defined: adds port flush_i (in, 1).
//   - flush_i=1 at an edge clears cnt and the pointers.
//   - Forces fifo_rinc_o=0 that cycle.
//   - Discards data returning from an in-flight read (RD_LAT=1).
//   - m_valid_o=0 from the next cycle.
//   - Flush does not drain the FIFO itself.
//  Undefined: port absent; logic behaves as flush_i tied 0.
// TESTING
//  T1 reset: rst_i=1 for 2 clk with fifo_rempty_i=0 -> fifo_rinc_o=0; after release m_valid_o=0, idle_o=1.
//  T2 stream: FIFO holds 0x11,0x22,0x33, m_ready_i=1, RD_LAT=0 -> m_data_o 0x11,0x22,0x33 on 3 consecutive clks, first 1 clk after the first pop.
//  T3 backpressure: m_ready_i=0 with 5 words in FIFO -> exactly 2 pops, level_o=2, m_data_o held at word 0; raise m_ready_i -> remaining words follow in order, no loss or duplication.
//  T4 empty boundary: FIFO drains to empty mid-stream -> fifo_rinc_o=0 while fifo_rempty_i=1; m_valid_o drops after the last take; no extra pop.
//  T5 RD_LAT=1: ready held high -> first word valid 2 clk after the pop, then 1 word/clk; toggle ready 1/0 each clk -> order preserved, cnt<=2.
//  T6 flush (macro on): level_o=2 with a read in flight, pulse flush_i -> m_valid_o=0 next clk, the in-flight word is dropped, and the next FIFO word is delivered.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer feeding a 2-entry valid/ready output queue.
// Optional flush port enabled by defining FIFO_RD_STREAM_FLUSH_EN.
module fifo_rd_stream #(
    parameter int DATA_SIZE = 8,
    parameter int RD_LAT    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef FIFO_RD_STREAM_FLUSH_EN
    input  logic                 flush_i,
`endif
    input  logic                 fifo_rempty_i,
    input  logic [DATA_SIZE-1:0] fifo_rdata_i,
    output logic                 fifo_rinc_o,
    output logic                 m_valid_o,
    output logic [DATA_SIZE-1:0] m_data_o,
    input  logic                 m_ready_i,
    output logic [1:0]           level_o,
    output logic                 idle_o
);

    logic [1:0]           cnt_q, cnt_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 inflight_q, inflight_d;
    logic [DATA_SIZE-1:0] buf_q [2];

    logic                 flush;
    logic                 take;
    logic                 wr_en;
    logic [2:0]           occ;

`ifdef FIFO_RD_STREAM_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = buf_q[rd_ptr_q];
    assign level_o   = cnt_q;
    assign idle_o    = (cnt_q == 2'd0) & ~inflight_q;
    assign take      = m_valid_o & m_ready_i;

    // Slots already promised: stored words plus the word still in flight.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, take};

    assign fifo_rinc_o = ~rst_i & ~flush & ~fifo_rempty_i & (occ < 3'd2);

    always_comb begin
        wr_en      = 1'b0;
        inflight_d = 1'b0;
        if (RD_LAT == 0) begin
            wr_en = fifo_rinc_o;
        end else begin
            wr_en      = inflight_q;
            inflight_d = fifo_rinc_o;
        end

        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (take) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({wr_en, take})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            wr_en      = 1'b0;
            inflight_d = 1'b0;
            cnt_d      = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            if (wr_en) begin
                buf_q[wr_ptr_q] <= fifo_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with RD_LAT=0 and RD_LAT=1 instances.
// Flush steps are included when FIFO_RD_STREAM_FLUSH_EN is defined.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [4:0] wcnt0, rptr0, wcnt1, rptr1;
    logic       rempty0, rempty1;
    logic [7:0] rdata0, rdata1;
    logic       rinc0, rinc1, valid0, valid1, ready0, ready1;
    logic       idle0, idle1;
    logic [7:0] data0, data1;
    logic [1:0] level0, level1;
    logic       flush0, flush1;

    always #5 clk = ~clk;

    assign rempty0 = (rptr0 == wcnt0);
    assign rempty1 = (rptr1 == wcnt1);
    assign rdata0  = mem0[rptr0[3:0]];

    always @(posedge clk) begin
        if (rst) begin
            rptr0 <= '0;
            rptr1 <= '0;
        end else begin
            if (rinc0) rptr0 <= rptr0 + 5'd1;
            if (rinc1) rptr1 <= rptr1 + 5'd1;
        end
        rdata1 <= mem1[rptr1[3:0]];
    end

    fifo_rd_stream #(.DATA_SIZE(8), .RD_LAT(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
`ifdef FIFO_RD_STREAM_FLUSH_EN
        .flush_i(flush0),
`endif
        .fifo_rempty_i(rempty0), .fifo_rdata_i(rdata0),
        .fifo_rinc_o(rinc0), .m_valid_o(valid0), .m_data_o(data0),
        .m_ready_i(ready0), .level_o(level0), .idle_o(idle0)
    );

    fifo_rd_stream #(.DATA_SIZE(8), .RD_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
`ifdef FIFO_RD_STREAM_FLUSH_EN
        .flush_i(flush1),
`endif
        .fifo_rempty_i(rempty1), .fifo_rdata_i(rdata1),
        .fifo_rinc_o(rinc1), .m_valid_o(valid1), .m_data_o(data1),
        .m_ready_i(ready1), .level_o(level1), .idle_o(idle1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("lvl0_max", {31'd0, level0 <= 2'd2}, 32'd1);
            chk("lvl1_max", {31'd0, level1 <= 2'd2}, 32'd1);
        end
    end

    initial begin
        int idx;
        rst = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        flush0 = 1'b0; flush1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00; mem1[i] = 8'h00;
        end
        mem0[0] = 8'hEE; wcnt0 = 5'd1; wcnt1 = 5'd0;

        // T1 reset holds pop low even with data present
        #1;
        chk("t1_rinc_rst_a", {31'd0, rinc0}, 32'd0);
        tick();
        chk("t1_rinc_rst_b", {31'd0, rinc0}, 32'd0);
        tick();
        chk("t1_rinc_rst_c", {31'd0, rinc0}, 32'd0);
        wcnt0 = 5'd0;
        rst   = 1'b0;
        #1;
        chk("t1_valid", {31'd0, valid0}, 32'd0);
        chk("t1_idle", {31'd0, idle0}, 32'd1);
        chk("t1_level", {30'd0, level0}, 32'd0);
        chk("t1_data", {24'd0, data0}, 32'd0);
        chk("t1_idle1", {31'd0, idle1}, 32'd1);

        // T2 streaming at ready high
        mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33;
        wcnt0 = 5'd3; ready0 = 1'b1;
        #1;
        chk("t2_rinc", {31'd0, rinc0}, 32'd1);
        tick();
        chk("t2_v1", {31'd0, valid0}, 32'd1);
        chk("t2_d1", {24'd0, data0}, 32'h11);
        tick();
        chk("t2_d2", {24'd0, data0}, 32'h22);
        tick();
        chk("t2_d3", {24'd0, data0}, 32'h33);
        chk("t4_rinc_empty", {31'd0, rinc0}, 32'd0);
        tick();
        chk("t2_vdrop", {31'd0, valid0}, 32'd0);
        chk("t2_idle", {31'd0, idle0}, 32'd1);

        // T3 backpressure: only two pops, head word held
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) mem0[3+i] = 8'hA0 + 8'(i);
        wcnt0 = 5'd8;
        tick();
        chk("t3_lvl1", {30'd0, level0}, 32'd1);
        tick();
        chk("t3_lvl2", {30'd0, level0}, 32'd2);
        chk("t3_rinc_full", {31'd0, rinc0}, 32'd0);
        tick();
        chk("t3_lvl2b", {30'd0, level0}, 32'd2);
        chk("t3_hold", {24'd0, data0}, 32'hA0);
        chk("t3_pops", {27'd0, rptr0}, 32'd5);
        ready0 = 1'b1;
        tick();
        chk("t3_d1", {24'd0, data0}, 32'hA1);
        tick();
        chk("t3_d2", {24'd0, data0}, 32'hA2);
        tick();
        chk("t3_d3", {24'd0, data0}, 32'hA3);
        chk("t4_rinc0", {31'd0, rinc0}, 32'd0);
        tick();
        chk("t3_d4", {24'd0, data0}, 32'hA4);
        chk("t3_lvl_last", {30'd0, level0}, 32'd1);
        tick();
        chk("t4_vdrop", {31'd0, valid0}, 32'd0);
        chk("t4_nopop", {27'd0, rptr0}, 32'd8);

        // T5 RD_LAT=1 latency and throughput
        mem1[0] = 8'h51; mem1[1] = 8'h52; mem1[2] = 8'h53; mem1[3] = 8'h54;
        wcnt1 = 5'd4; ready1 = 1'b1;
        #1;
        chk("t5_rinc", {31'd0, rinc1}, 32'd1);
        tick();
        chk("t5_v_lat1", {31'd0, valid1}, 32'd0);
        chk("t5_busy", {31'd0, idle1}, 32'd0);
        tick();
        chk("t5_v_lat2", {31'd0, valid1}, 32'd1);
        chk("t5_d1", {24'd0, data1}, 32'h51);
        tick();
        chk("t5_d2", {24'd0, data1}, 32'h52);
        tick();
        chk("t5_d3", {24'd0, data1}, 32'h53);
        tick();
        chk("t5_d4", {24'd0, data1}, 32'h54);
        tick();
        chk("t5_vdrop", {31'd0, valid1}, 32'd0);
        chk("t5_idle", {31'd0, idle1}, 32'd1);

        for (int i = 0; i < 6; i++) mem1[4+i] = 8'h61 + 8'(i);
        wcnt1 = 5'd10;
        idx = 0;
        for (int i = 0; i < 40; i++) begin
            ready1 = (i % 2 == 0);
            #1;
            if (valid1 && ready1) begin
                chk("t5_order", {24'd0, data1}, 32'h61 + 32'(idx));
                idx++;
            end
            tick();
        end
        chk("t5_count", 32'(idx), 32'd6);
        chk("t5_end_idle", {31'd0, idle1}, 32'd1);

`ifdef FIFO_RD_STREAM_FLUSH_EN
        // T6 flush drops queued and in-flight words
        ready1 = 1'b0;
        for (int i = 0; i < 5; i++) mem1[10+i] = 8'h71 + 8'(i);
        wcnt1 = 5'd15;
        tick();
        tick();
        tick();
        chk("t6_lvl2", {30'd0, level1}, 32'd2);
        ready1 = 1'b1;
        tick();
        chk("t6_inflight", {31'd0, idle1}, 32'd0);
        chk("t6_head", {24'd0, data1}, 32'h72);
        flush1 = 1'b1;
        #1;
        chk("t6_rinc_flush", {31'd0, rinc1}, 32'd0);
        tick();
        flush1 = 1'b0;
        chk("t6_vflush", {31'd0, valid1}, 32'd0);
        chk("t6_idle", {31'd0, idle1}, 32'd1);
        tick();
        tick();
        chk("t6_next_v", {31'd0, valid1}, 32'd1);
        chk("t6_next_d", {24'd0, data1}, 32'h74);
        tick();
        chk("t6_next_d2", {24'd0, data1}, 32'h75);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
